spram_arbiter: RTL

//  Two-requester arbiter that shares one spram instance (single-port,

---
 rtl/spram_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spram_arbiter.sv
// Two-requester arbiter sharing one single-port RAM (port 0 = CPU, port 1 = MARIA DMA).
// One grant per cycle; registered RAM-side signals; read data returns two cycles after grant.
module spram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_cs,
  output logic                  mem_wren,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  logic [1:0]            req;
  logic                  win_valid;
  logic                  win;
  logic                  sel_we;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  rr_last, rr_last_d;
  logic                  lock_valid, lock_valid_d;
  logic                  lock_owner, lock_owner_d;
  logic                  tag, tag_d;
  logic                  rd_pend, rd_pend_d;
  logic                  mem_cs_d, mem_wren_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic [DATA_WIDTH-1:0] mem_data_d;
  logic                  rvalid0_d, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;

  assign req = {req1, req0};

  // Winner selection: active lock first, then fixed priority or round-robin.
  always_comb begin
    win_valid = 1'b0;
    win       = 1'b0;
    if (lock_valid && req[lock_owner]) begin
      win_valid = 1'b1;
      win       = lock_owner;
    end else if ((FIXED_PRIO != 0) && req0) begin
      win_valid = 1'b1;
      win       = 1'b0;
    end else if (req0 && req1) begin
      win_valid = 1'b1;
      win       = ~rr_last;
    end else if (req0) begin
      win_valid = 1'b1;
      win       = 1'b0;
    end else if (req1) begin
      win_valid = 1'b1;
      win       = 1'b1;
    end
  end

  assign gnt0      = win_valid && !win;
  assign gnt1      = win_valid && win;
  assign sel_we    = win ? we1 : we0;
  assign sel_lock  = win ? lock1 : lock0;
  assign sel_addr  = win ? addr1 : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  // Next-state for the RAM request stage and the read-return stage.
  always_comb begin
    rr_last_d     = rr_last;
    lock_valid_d  = lock_valid;
    lock_owner_d  = lock_owner;
    tag_d         = tag;
    rd_pend_d     = 1'b0;
    mem_cs_d      = 1'b0;
    mem_wren_d    = 1'b0;
    mem_address_d = mem_address;
    mem_data_d    = mem_data;
    rvalid0_d     = rd_pend && !tag;
    rvalid1_d     = rd_pend && tag;
    rdata0_d      = rdata0;
    rdata1_d      = rdata1;

    if (win_valid) begin
      mem_cs_d      = 1'b1;
      mem_wren_d    = sel_we;
      mem_address_d = sel_addr;
      mem_data_d    = sel_wdata;
      tag_d         = win;
      rd_pend_d     = ~sel_we;
      rr_last_d     = win;
      lock_valid_d  = sel_lock;
      lock_owner_d  = sel_lock ? win : 1'b0;
    end else begin
      lock_valid_d  = lock_valid && req[lock_owner];
    end

    // mem_q is only trusted when a read is in flight; idle all-ones never leaks out.
    if (rd_pend && !tag) rdata0_d = mem_q;
    if (rd_pend && tag)  rdata1_d = mem_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last     <= 1'b1;
      lock_valid  <= 1'b0;
      lock_owner  <= 1'b0;
      tag         <= 1'b0;
      rd_pend     <= 1'b0;
      mem_cs      <= 1'b0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      rr_last     <= rr_last_d;
      lock_valid  <= lock_valid_d;
      lock_owner  <= lock_owner_d;
      tag         <= tag_d;
      rd_pend     <= rd_pend_d;
      mem_cs      <= mem_cs_d;
      mem_wren    <= mem_wren_d;
      mem_address <= mem_address_d;
      mem_data    <= mem_data_d;
      rvalid0     <= rvalid0_d;
      rvalid1     <= rvalid1_d;
      rdata0      <= rdata0_d;
      rdata1      <= rdata1_d;
    end
  end

endmodule
